// File: rtl/ksa_wb_ctrl_if.sv
// Wishbone classic slave bus bundle for the Kogge-Stone adder controller.
interface ksa_wb_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/ksa_wb_ctrl.sv
// Operand/result controller around the 16-bit Kogge-Stone adder.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for START; adder inputs hold last latched operands
//   RUN   | operands held on adder, settle counter running to capture
module ksa_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter int          SETTLE_CYCLES = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  ksa_wb_ctrl_if.slave         wb,
  output logic [15:0]          ksa_a,
  output logic [15:0]          ksa_b,
  input  logic [15:0]          ksa_sum,
  input  logic                 ksa_cout,
  output logic                 irq
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] REG_OPERAND = 2'd0;
  localparam logic [1:0] REG_CTRL    = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_RESULT  = 2'd3;

  state_t      state_q, state_d;
  logic [31:0] operand_q;
  logic        irq_en_q;
  logic        acc_q;
  logic        done_q;
  logic [16:0] result_q;
  logic [15:0] ksa_a_q, ksa_b_q;
  logic [3:0]  cnt_q;
  logic        ack_q;
  logic [31:0] dat_q;

  logic        req_valid;
  logic        wr_en, rd_en;
  logic [1:0]  reg_sel;
  logic        start_wr, done_clr, load, capture, busy;
  logic [31:0] rd_data;

  // Address bits below the word offset do not participate in decode.
  logic unused_adr;
  assign unused_adr = ^wb.wbs_adr_i[1:0];

  assign req_valid = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q &
                     (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr_en     = req_valid & wb.wbs_we_i;
  assign rd_en     = req_valid & ~wb.wbs_we_i;
  assign reg_sel   = wb.wbs_adr_i[3:2];

  assign start_wr  = wr_en & (reg_sel == REG_CTRL) & wb.wbs_sel_i[0] & wb.wbs_dat_i[0];
  assign done_clr  = wr_en & (reg_sel == REG_STATUS) & wb.wbs_sel_i[0] & wb.wbs_dat_i[1];
  assign busy      = (state_q == RUN);

  // Read mux sees pre-edge register values, so a capture-cycle read is pre-capture.
  always_comb begin
    rd_data = 32'd0;
    case (reg_sel)
      REG_OPERAND: rd_data = operand_q;
      REG_CTRL:    rd_data = {29'd0, acc_q, irq_en_q, 1'b0};
      REG_STATUS:  rd_data = {29'd0, result_q[16], done_q, busy};
      REG_RESULT:  rd_data = {15'd0, result_q};
      default:     rd_data = 32'd0;
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic; START while RUN falls through untouched.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_wr) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          capture = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Settle down-counter; capture fires when it reads zero in RUN.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                     cnt_q <= 4'd0;
    else if (load)                      cnt_q <= 4'(SETTLE_CYCLES - 1);
    else if (busy && cnt_q != 4'd0)     cnt_q <= cnt_q - 4'd1;
  end

  // Latched adder operands; only START updates them.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ksa_a_q <= 16'd0;
      ksa_b_q <= 16'd0;
    end else if (load) begin
      ksa_a_q <= acc_q ? result_q[15:0] : operand_q[15:0];
      ksa_b_q <= operand_q[31:16];
    end
  end

  // Result capture and DONE flag; capture has priority over W1C.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      result_q <= 17'd0;
      done_q   <= 1'b0;
    end else begin
      if (capture)       result_q <= {ksa_cout, ksa_sum};
      if (capture)       done_q   <= 1'b1;
      else if (load)     done_q   <= 1'b0;
      else if (done_clr) done_q   <= 1'b0;
    end
  end

  // Software-writable OPERAND and CTRL fields.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      operand_q <= 32'd0;
      irq_en_q  <= 1'b0;
      acc_q     <= 1'b0;
    end else if (wr_en) begin
      if (reg_sel == REG_OPERAND) begin
        for (int i = 0; i < 4; i++) begin
          if (wb.wbs_sel_i[i]) operand_q[8*i +: 8] <= wb.wbs_dat_i[8*i +: 8];
        end
      end
      if (reg_sel == REG_CTRL && wb.wbs_sel_i[0]) begin
        irq_en_q <= wb.wbs_dat_i[1];
        acc_q    <= wb.wbs_dat_i[2];
      end
    end
  end

  // Registered single-cycle ack with read data valid alongside it.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= 32'd0;
    end else begin
      ack_q <= req_valid;
      dat_q <= rd_en ? rd_data : 32'd0;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign ksa_a        = ksa_a_q;
  assign ksa_b        = ksa_b_q;
  assign irq          = done_q & irq_en_q;

endmodule

// File: tb/tb_ksa_wb_ctrl.sv
// Directed bench for ksa_wb_ctrl with a behavioural adder on the ksa ports.
module tb_ksa_wb_ctrl;

  localparam logic [31:0] A_OP   = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = 32'h3000_0004;
  localparam logic [31:0] A_STAT = 32'h3000_0008;
  localparam logic [31:0] A_RES  = 32'h3000_000C;
  localparam logic [31:0] A_BAD  = 32'h3000_0010;

  logic        clk;
  logic        rst_n;
  logic [15:0] ksa_a, ksa_b, ksa_sum;
  logic        ksa_cout;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;
  int irq_rises = 0;
  int rise_base;
  logic irq_d = 1'b0;

  ksa_wb_ctrl_if wb ();

  ksa_wb_ctrl #(.BASE_ADDR(32'h3000_0000), .SETTLE_CYCLES(2)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb       (wb),
    .ksa_a    (ksa_a),
    .ksa_b    (ksa_b),
    .ksa_sum  (ksa_sum),
    .ksa_cout (ksa_cout),
    .irq      (irq)
  );

  assign {ksa_cout, ksa_sum} = {1'b0, ksa_a} + {1'b0, ksa_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    irq_d <= irq;
    if (irq && !irq_d) irq_rises <= irq_rises + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdat, output int cyc);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = dat;
    wb.wbs_sel_i = sel;
    cyc  = 0;
    rdat = 32'd0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) begin
        cyc  = i;
        rdat = wb.wbs_dat_o;
        break;
      end
    end
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel);
    logic [31:0] rd;
    int cyc;
    xfer(1'b1, adr, dat, sel, rd, cyc);
    chk({tag, "_ack"}, 32'(cyc != 0), 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    int cyc;
    xfer(1'b0, adr, 32'd0, 4'hF, rd, cyc);
    chk({tag, "_ack"}, 32'(cyc != 0), 32'd1);
    chk(tag, rd, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    int cyc;
    logic [31:0] acc_exp [4];
    acc_exp[0] = 32'h0000_4000;
    acc_exp[1] = 32'h0000_8000;
    acc_exp[2] = 32'h0000_C000;
    acc_exp[3] = 32'h0001_0000;

    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = 32'd0;
    wb.wbs_dat_i = 32'd0;
    rst_n = 1'b0;
    idle(2);
    chk("rst_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
    chk("rst_dat", wb.wbs_dat_o, 32'd0);
    chk("rst_ksa", {ksa_b, ksa_a}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);

    // Basic add, busy window and capture timing
    wr("op1", A_OP, 32'h4321_1234, 4'hF);
    wr("start1", A_CTRL, 32'h1, 4'h1);
    chk("t1_ksa", {ksa_b, ksa_a}, 32'h4321_1234);
    rd_chk("t1_stat_capedge", A_STAT, 32'h1);
    rd_chk("t1_stat_done", A_STAT, 32'h2);
    rd_chk("t1_result", A_RES, 32'h0000_5555);

    // Carry out, irq latency and W1C
    wr("op2", A_OP, 32'h0001_FFFF, 4'hF);
    wr("start2", A_CTRL, 32'h3, 4'h1);
    chk("t2_irq_e0", {31'd0, irq}, 32'd0);
    idle(1);
    chk("t2_irq_e1", {31'd0, irq}, 32'd0);
    idle(1);
    chk("t2_irq_e2", {31'd0, irq}, 32'd1);
    rd_chk("t2_result", A_RES, 32'h0001_0000);
    rd_chk("t2_stat", A_STAT, 32'h6);
    wr("t2_w1c", A_STAT, 32'h2, 4'h1);
    chk("t2_irq_clr", {31'd0, irq}, 32'd0);
    rd_chk("t2_stat_clr", A_STAT, 32'h4);

    // Accumulate mode: A comes from previous sum
    wr("acc_on", A_CTRL, 32'h4, 4'h1);
    wr("op3", A_OP, 32'h4000_0000, 4'hF);
    for (int k = 0; k < 4; k++) begin
      wr("acc_start", A_CTRL, 32'h5, 4'h1);
      idle(4);
      rd_chk($sformatf("t3_acc%0d", k), A_RES, acc_exp[k]);
    end

    // OPERAND write during RUN leaves adder inputs alone
    wr("acc_off", A_CTRL, 32'h2, 4'h1);
    wr("op4", A_OP, 32'h0002_0003, 4'hF);
    wr("start4a", A_CTRL, 32'h3, 4'h1);
    wr("op4_run", A_OP, 32'hFFFF_FFFF, 4'hF);
    chk("t4a_ksa", {ksa_b, ksa_a}, 32'h0002_0003);
    rd_chk("t4a_result", A_RES, 32'h0000_0005);
    rd_chk("t4a_operand", A_OP, 32'hFFFF_FFFF);

    // START during RUN is acked but ignored
    rise_base = irq_rises;
    wr("start4b", A_CTRL, 32'h3, 4'h1);
    chk("t4b_ksa", {ksa_b, ksa_a}, 32'hFFFF_FFFF);
    wr("start4b_run", A_CTRL, 32'h3, 4'h1);
    idle(6);
    chk("t4b_rises", 32'(irq_rises - rise_base), 32'd1);
    rd_chk("t4b_stat", A_STAT, 32'h6);
    rd_chk("t4b_result", A_RES, 32'h0001_FFFE);

    // Reset one cycle into RUN
    wr("op5", A_OP, 32'h1111_2222, 4'hF);
    wr("start5", A_CTRL, 32'h3, 4'h1);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("t5_ksa", {ksa_b, ksa_a}, 32'd0);
    chk("t5_irq", {31'd0, irq}, 32'd0);
    chk("t5_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
    chk("t5_dat", wb.wbs_dat_o, 32'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle(4);
    rd_chk("t5_stat", A_STAT, 32'h0);
    rd_chk("t5_result", A_RES, 32'h0);
    chk("t5_irq_after", {31'd0, irq}, 32'd0);

    // Byte enables, CTRL readback, out-of-range address
    wr("op6", A_OP, 32'hAABB_CCDD, 4'h5);
    wr("ctrl6", A_CTRL, 32'h6, 4'h1);
    wr("ctrl6_nosel", A_CTRL, 32'h0, 4'hE);
    rd_chk("t6_ctrl", A_CTRL, 32'h6);
    xfer(1'b0, A_BAD, 32'd0, 4'hF, rd, cyc);
    chk("t6_bad_noack", 32'(cyc), 32'd0);
    xfer(1'b0, A_OP, 32'd0, 4'hF, rd, cyc);
    chk("t6_op_latency", 32'(cyc), 32'd1);
    chk("t6_op_data", rd, 32'h00BB_00DD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ksa_wb_ctrl.md
# ksa_wb_ctrl

Wishbone-slave operand/result controller that sits directly upstream and downstream of the 16-bit Kogge-Stone adder in the user project. It latches operands written by the management SoC and drives them onto the adder inputs, waits a programmable settle time, and captures sum/carry into a readable result register. It raises a completion status and an optional interrupt. An accumulate mode feeds the previous sum back as operand A.

## Interface
- BASE_ADDR, 32'h3000_0000: block base; decode on wbs_adr_i[31:4].
- SETTLE_CYCLES, 2: cycles operands are held before capture; legal 1..15.
- wb_clk_i  in  1  single clock.
- wb_rst_ni  in  1  reset: one clock; reset is asynchronous and active-low.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe/cycle/write.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  32  read data.
- ksa_a, ksa_b  out  16 each  adder operands.
- ksa_sum  in  16  adder sum.
- ksa_cout  in  1  adder carry-out.
- irq  out  1  completion interrupt, level.

## Operation
- Register map, selected by wbs_adr_i[3:2]:
  - 0x0 OPERAND (RW): [15:0] A, [31:16] B. Byte enables honoured.
  - 0x4 CTRL: bit0 START (write-1 pulse, reads 0), bit1 IRQ_EN (RW), bit2 ACC (RW). Written only when wbs_sel_i[0]=1.
  - 0x8 STATUS: bit0 BUSY (RO), bit1 DONE (W1C, needs sel[0]), bit2 COUT (RO copy of captured carry).
  - 0xC RESULT (RO): [15:0] sum, [16] cout, [31:17] 0.
- Access decode:
  - A request is valid when cyc & stb & adr[31:4]==BASE_ADDR[31:4] & !wbs_ack_o.
  - Non-matching addresses get no ack and have no effect.
  - Unused bits read 0. Writes to RO fields are ignored.
- FSM has two states, IDLE and RUN.
- IDLE to RUN on a START write:
  - ksa_a_q is loaded with RESULT.sum if ACC=1, otherwise with OPERAND.A.
  - ksa_b_q is loaded with OPERAND.B.
  - The counter is loaded with SETTLE_CYCLES-1.
  - DONE is cleared and BUSY is set.
- RUN decrements the counter each cycle. When the counter is 0:
  - RESULT is captured from {ksa_cout, ksa_sum}.
  - DONE is set, BUSY is cleared, and the FSM returns to IDLE.
- ksa_a and ksa_b are driven only from the latched copies. OPERAND writes during RUN update OPERAND but do not disturb the adder inputs.
- START during RUN is ignored, but the write is still acked.
- irq = DONE & IRQ_EN.

## Timing
- Reset values while wb_rst_ni=0:
  - wbs_ack_o=0, wbs_dat_o=0, ksa_a=0, ksa_b=0, irq=0.
  - All registers 0. FSM in IDLE.
- Reset mid-RUN aborts the operation immediately. RESULT returns to 0 and no DONE is produced.
- Bus protocol:
  - A valid request sampled at edge E drives wbs_ack_o=1 for exactly one cycle after E.
  - Read data is valid in that same cycle.
  - Writes take effect at E.
  - Minimum two cycles per access; a held strobe is serviced every other cycle.
- START write sampled at edge E:
  - BUSY, ksa_a and ksa_b update after E.
  - RESULT and DONE update at edge E+SETTLE_CYCLES. BUSY falls at the same edge.
  - irq is asserted after E+SETTLE_CYCLES when IRQ_EN=1.
- If a DONE W1C write coincides with the capture edge, set wins and DONE=1.
- A STATUS read in the capture cycle returns pre-capture values.
- ACC uses the RESULT value present at the START edge.
- Arithmetic is 16-bit modulo. Carry is reported only via RESULT[16] and STATUS.COUT.

## Test plan
- OPERAND=0x4321_1234, START, SETTLE_CYCLES=2 -> ksa_a=0x1234, ksa_b=0x4321; two edges later RESULT=0x0000_5555, STATUS=0x2; BUSY high for exactly 2 cycles.
- OPERAND=0x0001_FFFF, IRQ_EN=1, START -> RESULT=0x0001_0000, STATUS=0x6, irq=1; W1C STATUS bit1 -> irq=0, STATUS=0x4.
- ACC=1, OPERAND=0x4000_0000, four STARTs each awaited -> RESULT sums 0x4000, 0x8000, 0xC000, then 0x0000 with cout=1.
- START, then during RUN write OPERAND=0xFFFF_FFFF and START again -> ksa_a/ksa_b unchanged, single capture of the original sum, exactly one DONE rise.
- Deassert wb_rst_ni one cycle after START -> all outputs 0 immediately; after release STATUS=0, RESULT=0, irq=0.
- Read at address BASE_ADDR+0x10 -> no ack within 8 cycles; following valid read of OPERAND acks in 1 cycle.
